// File: rtl/irq_round_robin_sequencer.sv
// Shares one interrupt line among NUM_SRC channels: rising-edge capture, round-robin grant, one-cycle ack pulse.
// Define IRQ_TIMEOUT_EN to add a WAIT_ACK timeout with a sticky timeout_flag.
module irq_round_robin_sequencer #(
  parameter int NUM_SRC        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [NUM_SRC-1:0]  src_irq,
  input  logic                mask_we,
  input  logic [NUM_SRC-1:0]  mask_wdata,
  input  logic                ack_in,
  input  logic                tf_clr,
  output logic                irq_out,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic [NUM_SRC-1:0]  ack_out,
  output logic [NUM_SRC-1:0]  pending,
  output logic [NUM_SRC-1:0]  mask,
  output logic                busy,
  output logic                timeout_flag
);

  // Handshake: irq_out/irq_id form a level request held until the CPU pulses ack_in
  // (or the optional timeout fires); ack_out then echoes a one-cycle pulse to the granted channel.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [NUM_SRC-1:0]  src_prev_q;
  logic [NUM_SRC-1:0]  pending_q;
  logic [NUM_SRC-1:0]  pending_d;
  logic [NUM_SRC-1:0]  mask_q;
  logic [NUM_SRC-1:0]  ack_out_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] irq_id_q;
  logic                irq_out_q;

  logic [NUM_SRC-1:0]  rise;
  logic [NUM_SRC-1:0]  elig;
  logic [NUM_SRC-1:0]  id_onehot;
  logic [ID_WIDTH:0]   pick;
  logic [ID_WIDTH-1:0] rr_next;
  logic                ack_fire;
  logic                to_hit;

  // First set bit at or above ptr, wrapping; the downward loop leaves the nearest candidate last.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_SRC-1:0]  req,
                                                input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH:0]   res;
    logic [ID_WIDTH-1:0] cand;
    int                  idx;
    res = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      cand = ID_WIDTH'(idx);
      if (req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    rise      = src_irq & ~src_prev_q;
    elig      = pending_q & ~mask_q;
    pick      = rr_pick(elig, rr_ptr_q);
    id_onehot = NUM_SRC'(1) << irq_id_q;
    ack_fire  = (state_q == ST_WAIT_ACK) && ack_in;
    // A new edge in the ack cycle wins over the clear.
    pending_d = (pending_q & ~(ack_fire ? id_onehot : '0)) | rise;
    rr_next   = (irq_id_q == ID_WIDTH'(NUM_SRC - 1)) ? '0 : irq_id_q + ID_WIDTH'(1);
  end

`ifdef IRQ_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_q;
  logic                tf_q;

  assign to_hit = (state_q == ST_WAIT_ACK) && !ack_in &&
                  (to_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_q <= '0;
      tf_q     <= 1'b0;
    end else begin
      if (state_q == ST_GRANT) to_cnt_q <= '0;
      else if (state_q == ST_WAIT_ACK) to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
      if (to_hit) tf_q <= 1'b1;
      else if (tf_clr) tf_q <= 1'b0;
    end
  end

  assign timeout_flag = tf_q;
`else
  localparam int unused_to_cfg = TIMEOUT_CYCLES + TO_WIDTH;
  logic unused_tf_clr;
  assign unused_tf_clr = tf_clr;
  assign to_hit        = 1'b0;
  assign timeout_flag  = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      src_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      ack_out_q  <= '0;
      rr_ptr_q   <= '0;
      irq_id_q   <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      src_prev_q <= src_irq;
      pending_q  <= pending_d;
      ack_out_q  <= '0;
      if (mask_we) mask_q <= mask_wdata;
      case (state_q)
        ST_IDLE: begin
          if (pick[ID_WIDTH]) begin
            irq_id_q <= pick[ID_WIDTH-1:0];
            state_q  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          irq_out_q <= 1'b1;
          state_q   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ack_in) begin
            irq_out_q <= 1'b0;
            ack_out_q <= id_onehot;
            rr_ptr_q  <= rr_next;
            state_q   <= ST_RELEASE;
          end else if (to_hit) begin
            irq_out_q <= 1'b0;
            rr_ptr_q  <= rr_next;
            state_q   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          irq_out_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          irq_out_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_out = irq_out_q;
  assign irq_id  = irq_id_q;
  assign ack_out = ack_out_q;
  assign pending = pending_q;
  assign mask    = mask_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/irq_round_robin_sequencer.md
Name: irq_round_robin_sequencer

Overview:
- Shares the single external interrupt line between NUM_SRC counter/control channels. Each channel is a counter-enable control block that raises a request and clears its control register on ack_in.
- Captures request edges into a pending register and arbitrates round-robin among unmasked pending sources.
- Drives irq_out with the granted source ID, then sequences the acknowledge back to the granted channel as a one-cycle pulse.
- Sits between the per-channel control blocks and the CPU/PLIC interrupt input, on the APB clock domain.

Parameters:
- NUM_SRC, 4, number of requesting channels (2..16).
- ID_WIDTH, 2, width of irq_id; must satisfy 2**ID_WIDTH >= NUM_SRC.
- TIMEOUT_CYCLES, 255, ack timeout in PCLK cycles; used only with IRQ_TIMEOUT_EN.
- TO_WIDTH, 8, timeout counter width; must satisfy 2**TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- PCLK  input  1  single clock; all logic on its rising edge.
- PRESETn  input  1  asynchronous, active-low reset.
- src_irq  input  NUM_SRC  per-channel request; the rising edge is the event.
- mask_we  input  1  APB write strobe for the mask register.
- mask_wdata  input  NUM_SRC  mask write data; 1 = source masked.
- ack_in  input  1  CPU acknowledge for the currently granted interrupt.
- tf_clr  input  1  clears timeout_flag.
- irq_out  output  1  shared interrupt line.
- irq_id  output  ID_WIDTH  index of the granted source; valid while irq_out = 1.
- ack_out  output  NUM_SRC  one-hot, one-cycle ack pulse to the granted channel's ack_in.
- pending  output  NUM_SRC  pending register, visible to software.
- mask  output  NUM_SRC  mask register.
- busy  output  1  high in GRANT/WAIT_ACK/RELEASE.
- timeout_flag  output  1  sticky timeout indicator.

Behaviour:
- Reset values: all outputs and internal registers 0 (irq_out, irq_id, ack_out, pending, mask, busy, timeout_flag); rr_ptr = 0; state = IDLE.
- Reset asserted mid-operation: all of the above clear immediately; no ack_out pulse is produced.
- Edge capture: src_prev is registered each cycle. A rising edge (src_irq & ~src_prev) sets pending[i] on the next edge.
  - Pending is captured regardless of mask.
  - A held-high level does not re-set pending.
- Mask register: mask_we loads mask_wdata in the same cycle. Masking only removes a source from arbitration; it never revokes an active grant.
- Eligibility: elig = pending & ~mask, evaluated from registered values.
- IDLE: if elig != 0, select the first set bit searching upward from rr_ptr with wrap-around (NUM_SRC-1 -> 0). Latch it into irq_id and go to GRANT.
  - If elig == 0, stay in IDLE.
  - ack_in is ignored in IDLE.
- GRANT (1 cycle): irq_out <= 1, busy = 1, then go to WAIT_ACK.
- Latency: src edge at cycle n -> pending at n+1 -> GRANT at n+2 -> irq_out high from n+3.
- WAIT_ACK: hold irq_out and irq_id stable. On ack_in = 1, all of the following happen on the same edge:
  - irq_out <= 0.
  - ack_out[irq_id] <= 1 for exactly one cycle.
  - pending[irq_id] <= 0.
  - rr_ptr <= irq_id+1 (mod NUM_SRC).
  - Go to RELEASE.
- Simultaneous ack and new edge on the same source: set wins, so pending stays 1. That source gets lowest priority next round because rr_ptr has advanced past it.
- RELEASE (1 cycle): irq_out = 0, then go to IDLE. This guarantees at least 2 low cycles on irq_out between consecutive grants.
- Invalid state encoding recovers to IDLE.
- tf_clr clears timeout_flag; if a timeout sets the flag in the same cycle, the set wins.

Optional Feature:
- Macro: IRQ_TIMEOUT_EN.
- Defined:
  - A TO_WIDTH counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle.
  - If it reaches TIMEOUT_CYCLES with no ack_in: irq_out <= 0, no ack_out pulse, pending is retained, timeout_flag <= 1, rr_ptr <= irq_id+1, go to RELEASE.
  - An ack_in arriving in the same cycle as the timeout takes priority (normal ack path).
- Undefined: WAIT_ACK waits indefinitely, timeout_flag is tied 0, and no counter is synthesised.

Test Plan:
- Reset then src_irq[2] rising at cycle 10 -> pending = 4'b0100 at 11, irq_out = 1 and irq_id = 2 from cycle 13; ack_in at 20 -> ack_out = 4'b0100 for one cycle, pending = 0, irq_out low.
- src_irq[0] and src_irq[3] rise together with rr_ptr = 0 -> grant 0 first; after ack, grant 3; after ack, rr_ptr = 0.
- mask = 4'b0010, src_irq[1] rises -> pending[1] = 1, no irq_out; write mask = 0 -> grant id 1 within 2 cycles.
- During WAIT_ACK for id 1, src_irq[1] re-rises in the ack cycle -> pending[1] stays 1; the other pending sources are served before id 1.
- IRQ_TIMEOUT_EN with TIMEOUT_CYCLES = 8, no ack -> irq_out drops after 8 WAIT_ACK cycles, timeout_flag = 1, pending bit retained; tf_clr -> flag = 0.
- PRESETn asserted during WAIT_ACK -> irq_out, pending, mask, and ack_out all 0 asynchronously; state returns to IDLE.
